pwm_ramp_ctrl: RTL and testbench
================================

Name: pwm_ramp_ctrl

Overview:
Dual-channel controller that generates the 11-bit duty words and direction bits for the left and right PWM11 motor drivers.
- Accepts signed speed commands.
- Slews each channel's duty toward its target by a bounded step once per PWM period.
- On a direction reversal, ramps the channel down to zero, holds a dead-time, then flips direction.
- A fault input forces both duties to zero immediately.

Parameters:
STEP, 64, maximum duty change per PWM period (1..2047)
DEAD_PERIODS, 2, whole PWM periods of zero duty before a direction flip (1..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  drive enable; when low, both targets are treated as 0
spd_vld  in  1  one-cycle strobe; captures lft_spd/rght_spd as new targets
lft_spd  in  12  signed left speed command
rght_spd  in  12  signed right speed command
flt  in  1  fault; level-sensitive
flt_clr  in  1  one-cycle strobe; releases fault latch if flt is low
lft_duty  out  11  duty word to left PWM11
rght_duty  out  11  duty word to right PWM11
lft_rev  out  1  left direction (1 = reverse)
rght_rev  out  1  right direction
period_tick  out  1  high for one cycle when the period counter is 2047
busy  out  1  high while either channel is not settled at its target
flt_lat  out  1  latched fault status

Behaviour:
- Reset values: all duties 0, rev 0, period_tick 0, busy 0, flt_lat 0, period counter 0, targets 0, all channels in HOLD.
- The period counter is 11 bits, free-running and wraps at 2047 -> 0. It is reset by the same rst as the PWM11 instances, so it stays cycle-aligned with them.
- period_tick is combinational: asserted when cnt == 2047.
- Target capture: on spd_vld, each target magnitude is |spd|, with -2048 saturated to 2047. Target direction is the sign bit; zero is treated as the current direction (no flip).
- spd_vld may arrive in any cycle. It is registered only, never applied until the next period_tick.
- If spd_vld coincides with period_tick, the new targets are used on that tick.
- Duty and rev outputs change only on the clock edge where period_tick = 1, so they take effect at cnt = 0.
- Per-channel FSM, evaluated on period_tick:
  - HOLD: duty == target and direction matches target direction.
    - Target magnitude differs, same direction -> SLEW.
    - Direction differs -> SLEW toward 0.
  - SLEW: duty moves toward the goal by min(STEP, |goal - duty|). The goal is the target magnitude, or 0 when a reversal is pending.
    - Goal reached with no reversal pending -> HOLD.
    - Duty reaches 0 with a reversal pending -> DWELL, dwell counter = DEAD_PERIODS.
  - DWELL: duty held at 0; counter decrements each tick.
    - On the tick where the counter reaches 0: rev toggles, then -> SLEW toward the new magnitude.
    - The flipped rev and the first nonzero duty appear no earlier than the following tick.
- A target change during SLEW or DWELL re-evaluates the goal on the next tick. A reversal cancelled during DWELL still completes the dwell, then -> SLEW without flipping.
- Arithmetic is 12-bit unsigned internally; duty never underflows below 0 or exceeds 2047.
- Fault handling:
  - flt = 1 sets flt_lat on the next edge (any cycle, not tick-aligned).
  - While flt_lat = 1: duties are forced to 0 immediately, FSMs are held in DWELL with counter = DEAD_PERIODS, and rev is unchanged.
  - flt_clr with flt = 0 clears flt_lat. flt_clr is ignored while flt = 1.
  - After clear, channels resume through normal DWELL then SLEW.
- en = 0 behaves as target magnitude 0 (controlled ramp-down, no dwell unless a reversal is pending).
- busy = OR over channels of (state != HOLD), or flt_lat.
- rst asserted mid-operation returns everything to reset values asynchronously.

Decomposition:
- Package pwm_ctrl_pkg:
  - ch_state_t enum {HOLD, SLEW, DWELL}
  - PERIOD_MAX = 11'h7FF
  - DUTY_W = 11
  - SPD_W = 12
- One natural sub-module, pwm_ramp_chan: a single channel's FSM, slew arithmetic and dwell counter. It is instantiated twice.
- Top level owns the period counter, target capture, fault latch and busy.

Test Plan:
- Reset, then lft_spd = +512 strobed with STEP = 64 -> lft_duty steps 64, 128, ..., 512 on 8 consecutive period_ticks; then HOLD; busy drops on the 8th tick edge; rght_duty stays 0.
- From +256 settled, command -256 (DEAD_PERIODS = 2) -> duty 192, 128, 64, 0 on 4 ticks; 2 ticks at 0; lft_rev = 1 on the tick that ends the dwell; then duty 64, ..., 256 on the next 4 ticks.
- lft_spd = -2048 -> target saturates to 2047 with rev set after dwell; final duty 2047 with no wrap; +100 with STEP = 64 -> 64 then 100.
- flt pulsed mid-ramp at duty 320 -> both duties 0 on the next edge, flt_lat = 1. flt_clr while flt = 1 is ignored. After flt drops and flt_clr is strobed: 2 ticks at 0, then ramp from 64.
- spd_vld mid-period -> duties unchanged until cnt == 2047; spd_vld on the period_tick cycle applies on that tick.
- rst asserted mid-SLEW -> all outputs 0 asynchronously. After release, period_tick first appears 2048 cycles later.

Source files
------------

// File: rtl/pwm_ramp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ctrl_pkg
// Purpose  : Shared types, widths and helpers for the dual-channel PWM ramp
//            controller (channel FSM state, duty/speed widths, period length).
// Contents : ch_state_t  - per-channel FSM state
//            PERIOD_MAX  - last count of the 11-bit PWM period counter
//            DUTY_W      - duty word width
//            SPD_W       - signed speed command width
//            spd_to_mag  - |speed| saturated to the duty range
// Revision : 1.0 - initial release
// ============================================================================
package pwm_ctrl_pkg;

    localparam int DUTY_W = 11;
    localparam int SPD_W  = 12;

    localparam logic [DUTY_W-1:0] PERIOD_MAX = 11'h7FF;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        SLEW  = 2'd1,
        DWELL = 2'd2
    } ch_state_t;

    // Two's-complement magnitude; -2048 has no 11-bit magnitude and clamps
    // to full scale.
    function automatic logic [DUTY_W-1:0] spd_to_mag(input logic [SPD_W-1:0] spd);
        logic [SPD_W-1:0] abs_v;
        abs_v = spd[SPD_W-1] ? (~spd + SPD_W'(1)) : spd;
        return abs_v[SPD_W-1] ? {DUTY_W{1'b1}} : abs_v[DUTY_W-1:0];
    endfunction

endpackage : pwm_ctrl_pkg
`default_nettype wire

// File: rtl/pwm_ramp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_ctrl_if
// Purpose  : Command/status bundle between a motion master and the PWM ramp
//            controller.
// Signals  : en, spd_vld, lft_spd, rght_spd, flt, flt_clr  (master -> ctrl)
//            lft_duty, rght_duty, lft_rev, rght_rev,
//            period_tick, busy, flt_lat                    (ctrl -> master)
// Modports : master - command source, slave - controller
// Revision : 1.0 - initial release
// ============================================================================
interface pwm_ramp_ctrl_if;
    import pwm_ctrl_pkg::*;

    logic              en;
    logic              spd_vld;
    logic [SPD_W-1:0]  lft_spd;
    logic [SPD_W-1:0]  rght_spd;
    logic              flt;
    logic              flt_clr;

    logic [DUTY_W-1:0] lft_duty;
    logic [DUTY_W-1:0] rght_duty;
    logic              lft_rev;
    logic              rght_rev;
    logic              period_tick;
    logic              busy;
    logic              flt_lat;

    modport master (
        output en, spd_vld, lft_spd, rght_spd, flt, flt_clr,
        input  lft_duty, rght_duty, lft_rev, rght_rev, period_tick, busy, flt_lat
    );

    modport slave (
        input  en, spd_vld, lft_spd, rght_spd, flt, flt_clr,
        output lft_duty, rght_duty, lft_rev, rght_rev, period_tick, busy, flt_lat
    );

endinterface : pwm_ramp_ctrl_if
`default_nettype wire

// File: rtl/pwm_ramp_ctrl_chan.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_chan
// Purpose  : One motor channel: slews the duty word toward the target by at
//            most STEP per PWM period, and on a direction change ramps to
//            zero, waits DEAD_PERIODS periods, then flips direction.
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            i_tick        - last cycle of the PWM period (update strobe)
//            i_force       - fault: zero duty now, park in DWELL
//            i_tgt_mag     - target duty magnitude
//            i_tgt_rev     - target direction (1 = reverse)
//            o_duty        - registered duty word
//            o_rev         - registered direction
//            o_busy        - channel not settled (state != HOLD)
// Revision : 1.0 - initial release
// ============================================================================
module pwm_ramp_chan
    import pwm_ctrl_pkg::*;
#(
    parameter int STEP         = 64,
    parameter int DEAD_PERIODS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tick,
    input  logic              i_force,
    input  logic [DUTY_W-1:0] i_tgt_mag,
    input  logic              i_tgt_rev,
    output logic [DUTY_W-1:0] o_duty,
    output logic              o_rev,
    output logic              o_busy
);

    localparam logic [DUTY_W:0] c_step = (DUTY_W+1)'(STEP);
    localparam logic [3:0]      c_dead = 4'(DEAD_PERIODS);

    ch_state_t         r_state;
    logic [DUTY_W-1:0] r_duty;
    logic              r_rev;
    logic [3:0]        r_dwell;

    logic              w_rev_pend;
    logic [DUTY_W:0]   w_goal;
    logic [DUTY_W:0]   w_cur;
    logic              w_up;
    logic [DUTY_W:0]   w_diff;
    logic [DUTY_W:0]   w_delta;
    logic [DUTY_W:0]   w_sum;
    logic [DUTY_W-1:0] w_next;

    // Slew arithmetic is one bit wider than the duty word so the difference
    // and the step never wrap; the result is clamped back to full scale.
    always_comb begin
        w_rev_pend = (i_tgt_rev != r_rev);
        w_goal     = w_rev_pend ? '0 : {1'b0, i_tgt_mag};
        w_cur      = {1'b0, r_duty};
        w_up       = (w_goal >= w_cur);
        w_diff     = w_up ? (w_goal - w_cur) : (w_cur - w_goal);
        w_delta    = (w_diff < c_step) ? w_diff : c_step;
        w_sum      = w_up ? (w_cur + w_delta) : (w_cur - w_delta);
        w_next     = w_sum[DUTY_W] ? {DUTY_W{1'b1}} : w_sum[DUTY_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HOLD;
            r_duty  <= '0;
            r_rev   <= 1'b0;
            r_dwell <= '0;
        end else if (i_force) begin
            // Direction is kept; the parked dwell makes recovery go through
            // a full dead-time before any duty is applied again.
            r_state <= DWELL;
            r_duty  <= '0;
            r_dwell <= c_dead;
        end else if (i_tick) begin
            case (r_state)
                HOLD, SLEW: begin
                    // HOLD steps on the same tick it notices a new target, so
                    // the first increment lands on the first tick.
                    r_duty <= w_next;
                    if (w_rev_pend && (w_next == '0)) begin
                        r_state <= DWELL;
                        r_dwell <= c_dead;
                    end else if (!w_rev_pend && (w_next == i_tgt_mag)) begin
                        r_state <= HOLD;
                    end else begin
                        r_state <= SLEW;
                    end
                end
                DWELL: begin
                    if (r_dwell <= 4'd1) begin
                        // Dwell always runs out; flip only if the reversal
                        // is still wanted at this point.
                        r_dwell <= '0;
                        r_state <= SLEW;
                        if (w_rev_pend) begin
                            r_rev <= ~r_rev;
                        end
                    end else begin
                        r_dwell <= r_dwell - 4'd1;
                    end
                end
                default: begin
                    r_state <= HOLD;
                end
            endcase
        end
    end

    assign o_duty = r_duty;
    assign o_rev  = r_rev;
    assign o_busy = (r_state != HOLD);

endmodule : pwm_ramp_chan
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_ctrl
// Purpose  : Dual-channel duty/direction generator for the left and right
//            PWM11 drivers. Owns the period counter (kept in step with the
//            PWM11 counters by the shared reset), target capture, fault
//            latch and the busy summary; the ramp FSMs live in pwm_ramp_chan.
// Ports    : clk           - system clock
//            rst           - asynchronous active-high reset
//            bus (slave)   - en, spd_vld, lft_spd, rght_spd, flt, flt_clr in;
//                            lft_duty, rght_duty, lft_rev, rght_rev,
//                            period_tick, busy, flt_lat out
// Revision : 1.0 - initial release
// ============================================================================
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int STEP         = 64,
    parameter int DEAD_PERIODS = 2
) (
    input  logic           clk,
    input  logic           rst,
    pwm_ramp_ctrl_if.slave bus
);

    logic [DUTY_W-1:0] r_cnt;
    logic              w_tick;

    logic [DUTY_W-1:0] r_lft_mag;
    logic [DUTY_W-1:0] r_rght_mag;
    logic              r_lft_dir;
    logic              r_rght_dir;
    logic              r_flt_lat;

    logic [DUTY_W-1:0] w_lft_cap_mag;
    logic [DUTY_W-1:0] w_rght_cap_mag;
    logic              w_lft_cap_dir;
    logic              w_rght_cap_dir;
    logic [DUTY_W-1:0] w_lft_mag;
    logic [DUTY_W-1:0] w_rght_mag;
    logic              w_lft_dir;
    logic              w_rght_dir;
    logic              w_force;

    logic [DUTY_W-1:0] w_lft_duty;
    logic [DUTY_W-1:0] w_rght_duty;
    logic              w_lft_rev;
    logic              w_rght_rev;
    logic              w_lft_busy;
    logic              w_rght_busy;

    // ------------------------------------------------------------------
    // Free-running period counter, wraps 2047 -> 0
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DUTY_W'(1);
        end
    end

    assign w_tick = (r_cnt == PERIOD_MAX);

    // ------------------------------------------------------------------
    // Target capture. A zero command keeps the present direction so that
    // stopping never triggers a reversal dwell.
    // ------------------------------------------------------------------
    always_comb begin
        w_lft_cap_mag  = spd_to_mag(bus.lft_spd);
        w_rght_cap_mag = spd_to_mag(bus.rght_spd);
        w_lft_cap_dir  = (bus.lft_spd == '0)  ? w_lft_rev  : bus.lft_spd[SPD_W-1];
        w_rght_cap_dir = (bus.rght_spd == '0) ? w_rght_rev : bus.rght_spd[SPD_W-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lft_mag  <= '0;
            r_rght_mag <= '0;
            r_lft_dir  <= 1'b0;
            r_rght_dir <= 1'b0;
        end else if (bus.spd_vld) begin
            r_lft_mag  <= w_lft_cap_mag;
            r_rght_mag <= w_rght_cap_mag;
            r_lft_dir  <= w_lft_cap_dir;
            r_rght_dir <= w_rght_cap_dir;
        end
    end

    // A strobe in the tick cycle itself bypasses the target registers so it
    // takes effect on that tick rather than a period later.
    always_comb begin
        w_lft_mag  = bus.spd_vld ? w_lft_cap_mag  : r_lft_mag;
        w_rght_mag = bus.spd_vld ? w_rght_cap_mag : r_rght_mag;
        w_lft_dir  = bus.spd_vld ? w_lft_cap_dir  : r_lft_dir;
        w_rght_dir = bus.spd_vld ? w_rght_cap_dir : r_rght_dir;
        if (!bus.en) begin
            w_lft_mag  = '0;
            w_rght_mag = '0;
        end
    end

    // ------------------------------------------------------------------
    // Fault latch. Clear is only honoured once the fault source is gone.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flt_lat <= 1'b0;
        end else if (bus.flt) begin
            r_flt_lat <= 1'b1;
        end else if (bus.flt_clr) begin
            r_flt_lat <= 1'b0;
        end
    end

    // Raw flt is included so the duties drop on the same edge that sets the
    // latch instead of one cycle later.
    assign w_force = bus.flt | r_flt_lat;

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    pwm_ramp_chan #(
        .STEP         (STEP),
        .DEAD_PERIODS (DEAD_PERIODS)
    ) u_lft (
        .clk       (clk),
        .rst       (rst),
        .i_tick    (w_tick),
        .i_force   (w_force),
        .i_tgt_mag (w_lft_mag),
        .i_tgt_rev (w_lft_dir),
        .o_duty    (w_lft_duty),
        .o_rev     (w_lft_rev),
        .o_busy    (w_lft_busy)
    );

    pwm_ramp_chan #(
        .STEP         (STEP),
        .DEAD_PERIODS (DEAD_PERIODS)
    ) u_rght (
        .clk       (clk),
        .rst       (rst),
        .i_tick    (w_tick),
        .i_force   (w_force),
        .i_tgt_mag (w_rght_mag),
        .i_tgt_rev (w_rght_dir),
        .o_duty    (w_rght_duty),
        .o_rev     (w_rght_rev),
        .o_busy    (w_rght_busy)
    );

    assign bus.lft_duty    = w_lft_duty;
    assign bus.rght_duty   = w_rght_duty;
    assign bus.lft_rev     = w_lft_rev;
    assign bus.rght_rev    = w_rght_rev;
    assign bus.period_tick = w_tick;
    assign bus.busy        = w_lft_busy | w_rght_busy | r_flt_lat;
    assign bus.flt_lat     = r_flt_lat;

endmodule : pwm_ramp_ctrl
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_ramp_ctrl
// Purpose  : Self-checking bench for pwm_ramp_ctrl. Two instances share the
//            clock/reset: m (STEP=64, DEAD_PERIODS=2) for the ramp, reversal,
//            fault and reset scenarios, a (STEP=2047, DEAD_PERIODS=1) for
//            saturation, no-wrap and enable-off in few periods. Expected
//            per-tick outputs are queued when commands are issued and
//            popped after each period_tick edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_ramp_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    initial forever #5 clk = ~clk;

    pwm_ramp_ctrl_if m ();
    pwm_ramp_ctrl_if a ();

    pwm_ramp_ctrl #(.STEP(64), .DEAD_PERIODS(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (m.slave)
    );

    pwm_ramp_ctrl #(.STEP(2047), .DEAD_PERIODS(1)) u_aux (
        .clk (clk),
        .rst (rst),
        .bus (a.slave)
    );

    typedef struct {
        logic [10:0] ld;
        logic        lr;
        logic [10:0] rd;
        logic        rr;
        logic        bz;
    } exp_t;

    exp_t q_m[$];
    exp_t q_a[$];

    int n_cmp  = 0;
    int n_err  = 0;
    int tick_n = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic void push_m(input int ld, input int lr, input int rd, input int rr, input int bz);
        exp_t e;
        e.ld = 11'(ld); e.lr = 1'(lr); e.rd = 11'(rd); e.rr = 1'(rr); e.bz = 1'(bz);
        q_m.push_back(e);
    endfunction

    function automatic void push_a(input int ld, input int lr, input int rd, input int rr, input int bz);
        exp_t e;
        e.ld = 11'(ld); e.lr = 1'(lr); e.rd = 11'(rd); e.rr = 1'(rr); e.bz = 1'(bz);
        q_a.push_back(e);
    endfunction

    // Wait (bounded) for the tick cycle, optionally strobe spd_vld in it,
    // then compare both instances just after the tick edge.
    task automatic tick_check(input bit strobe);
        int   n;
        exp_t e;
        n = 0;
        while (!m.period_tick && n < 2100) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("t%0d_tick_wait", tick_n + 1), 32'(m.period_tick), 1);
        if (strobe) m.spd_vld = 1'b1;
        @(posedge clk); #1;
        m.spd_vld = 1'b0;
        tick_n++;
        if (q_m.size() > 0) begin
            e = q_m.pop_front();
            chk($sformatf("t%0d_m_lduty", tick_n), 32'(m.lft_duty),  32'(e.ld));
            chk($sformatf("t%0d_m_lrev",  tick_n), 32'(m.lft_rev),   32'(e.lr));
            chk($sformatf("t%0d_m_rduty", tick_n), 32'(m.rght_duty), 32'(e.rd));
            chk($sformatf("t%0d_m_rrev",  tick_n), 32'(m.rght_rev),  32'(e.rr));
            chk($sformatf("t%0d_m_busy",  tick_n), 32'(m.busy),      32'(e.bz));
        end
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            chk($sformatf("t%0d_a_lduty", tick_n), 32'(a.lft_duty),  32'(e.ld));
            chk($sformatf("t%0d_a_lrev",  tick_n), 32'(a.lft_rev),   32'(e.lr));
            chk($sformatf("t%0d_a_rduty", tick_n), 32'(a.rght_duty), 32'(e.rd));
            chk($sformatf("t%0d_a_rrev",  tick_n), 32'(a.rght_rev),  32'(e.rr));
            chk($sformatf("t%0d_a_busy",  tick_n), 32'(a.busy),      32'(e.bz));
        end
    endtask

    task automatic strobe_m();
        m.spd_vld = 1'b1;
        @(posedge clk); #1;
        m.spd_vld = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        m.en = 1'b1; m.spd_vld = 1'b0; m.lft_spd = '0; m.rght_spd = '0; m.flt = 1'b0; m.flt_clr = 1'b0;
        a.en = 1'b1; a.spd_vld = 1'b0; a.lft_spd = '0; a.rght_spd = '0; a.flt = 1'b0; a.flt_clr = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_lduty",  32'(m.lft_duty),    0);
        chk("rst_rduty",  32'(m.rght_duty),   0);
        chk("rst_lrev",   32'(m.lft_rev),     0);
        chk("rst_rrev",   32'(m.rght_rev),    0);
        chk("rst_tick",   32'(m.period_tick), 0);
        chk("rst_busy",   32'(m.busy),        0);
        chk("rst_fltlat", 32'(m.flt_lat),     0);

        // Release with the counter at 0; the tick is the 2048th cycle.
        rst = 1'b0;
        n = 0;
        while (!m.period_tick && n < 2100) begin
            @(posedge clk); #1;
            n++;
            if (n == 10) begin
                m.lft_spd = 12'd512; m.rght_spd = 12'd0; m.spd_vld = 1'b1;
                a.lft_spd = 12'h800; a.rght_spd = 12'd2047; a.spd_vld = 1'b1;
                for (int i = 1; i <= 8; i++) push_m(64 * i, 0, 0, 0, (i < 8) ? 1 : 0);
                push_m(512, 0, 0, 0, 0);
                // -2048 saturates to 2047, needs a 1-period dwell first
                push_a(0,    0, 2047, 0, 1);
                push_a(0,    1, 2047, 0, 1);
                push_a(2047, 1, 2047, 0, 0);
                push_a(2047, 1, 2047, 0, 0);
            end else if (n == 11) begin
                m.spd_vld = 1'b0; a.spd_vld = 1'b0;
            end else if (n == 100) begin
                chk("midper_lduty0", 32'(m.lft_duty), 0);
            end
        end
        chk("first_tick_lat", 32'(n), 2047);

        // Ramp up to 512; aux saturation runs alongside, then en drops.
        for (int i = 0; i < 9; i++) begin
            tick_check(1'b0);
            if (i == 3) begin
                a.en = 1'b0;
                push_a(0, 1, 0, 0, 0);
                push_a(0, 1, 0, 0, 0);
            end
        end

        // Mid-period command: left down to 256, right +100 (64 then 100).
        m.lft_spd = 12'd256; m.rght_spd = 12'd100;
        push_m(448, 0,  64, 0, 1);
        push_m(384, 0, 100, 0, 1);
        push_m(320, 0, 100, 0, 1);
        push_m(256, 0, 100, 0, 0);
        strobe_m();
        repeat (100) @(posedge clk);
        #1;
        chk("midper_hold512", 32'(m.lft_duty), 512);
        for (int i = 0; i < 4; i++) tick_check(1'b0);

        // Reversal to -256 strobed in the tick cycle itself.
        m.lft_spd = 12'(-256);
        push_m(192, 0, 100, 0, 1);
        push_m(128, 0, 100, 0, 1);
        push_m(64,  0, 100, 0, 1);
        push_m(0,   0, 100, 0, 1);
        push_m(0,   0, 100, 0, 1);
        push_m(0,   1, 100, 0, 1);
        push_m(64,  1, 100, 0, 1);
        push_m(128, 1, 100, 0, 1);
        push_m(192, 1, 100, 0, 1);
        push_m(256, 1, 100, 0, 0);
        tick_check(1'b1);
        for (int i = 0; i < 9; i++) tick_check(1'b0);

        // Fault mid-ramp at duty 320.
        m.lft_spd = 12'(-512);
        push_m(320, 1, 100, 0, 1);
        strobe_m();
        tick_check(1'b0);
        repeat (20) @(posedge clk);
        #1;
        m.flt = 1'b1;
        @(posedge clk); #1;
        chk("flt_lduty",  32'(m.lft_duty),  0);
        chk("flt_rduty",  32'(m.rght_duty), 0);
        chk("flt_lat",    32'(m.flt_lat),   1);
        chk("flt_lrev",   32'(m.lft_rev),   1);
        chk("flt_rrev",   32'(m.rght_rev),  0);
        chk("flt_busy",   32'(m.busy),      1);
        m.flt_clr = 1'b1;
        @(posedge clk); #1;
        m.flt_clr = 1'b0;
        chk("flt_clr_ignored", 32'(m.flt_lat), 1);
        m.flt = 1'b0;
        @(posedge clk); #1;
        chk("flt_lat_held", 32'(m.flt_lat), 1);
        m.flt_clr = 1'b1;
        @(posedge clk); #1;
        m.flt_clr = 1'b0;
        chk("flt_cleared",    32'(m.flt_lat), 0);
        chk("flt_busy_dwell", 32'(m.busy),    1);
        push_m(0,   1,   0, 0, 1);
        push_m(0,   1,   0, 0, 1);
        push_m(64,  1,  64, 0, 1);
        push_m(128, 1, 100, 0, 1);
        for (int i = 0; i < 4; i++) tick_check(1'b0);

        // Asynchronous reset mid-slew, checked before the next clock edge.
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        chk("arst_lduty",  32'(m.lft_duty),    0);
        chk("arst_rduty",  32'(m.rght_duty),   0);
        chk("arst_lrev",   32'(m.lft_rev),     0);
        chk("arst_busy",   32'(m.busy),        0);
        chk("arst_fltlat", 32'(m.flt_lat),     0);
        chk("arst_tick",   32'(m.period_tick), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        while (!m.period_tick && n < 2100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rerst_tick_lat", 32'(n), 2047);
        push_m(0, 0, 0, 0, 0);
        tick_check(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pwm_ramp_ctrl
`default_nettype wire
